// File: rtl/cmp_pkg.sv
// cmp_pkg: op and FSM state encodings plus legal-op helper for the iterative comparator
package cmp_pkg;
    localparam logic [2:0] CMP_EQ  = 3'b000;
    localparam logic [2:0] CMP_NE  = 3'b001;
    localparam logic [2:0] CMP_LT  = 3'b100;
    localparam logic [2:0] CMP_GE  = 3'b101;
    localparam logic [2:0] CMP_LTU = 3'b110;
    localparam logic [2:0] CMP_GEU = 3'b111;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    function automatic logic op_legal(input logic [2:0] op);
        return op[2] || !op[1];
    endfunction
endpackage

// File: rtl/cmp_chunk_nb.sv
// cmp_chunk_nb: combinational unsigned compare of one CHUNK-bit slice
module cmp_chunk_nb #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             lt,
    output logic             eq
);
    assign lt = a < b;
    assign eq = a == b;
endmodule

// File: rtl/compare_iter_nb.sv
// compare_iter_nb: iterative RISC-V branch/set comparator, CHUNK bits per cycle, MSB chunk first
// Define CMP_EARLY_EXIT_EN to leave RUN on the first differing chunk (data-dependent latency).
module compare_iter_nb
    import cmp_pkg::*;
#(
    parameter int N     = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic [2:0]   op_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [N-1:0] r_o,
    output logic         err_o
);
    localparam int K  = N / CHUNK;
    localparam int IW = (K > 1) ? $clog2(K) : 1;
    localparam logic [IW-1:0] LAST = IW'(K - 1);

    generate
        if (CHUNK < 1 || CHUNK > N || (N % CHUNK) != 0) begin : g_bad_cfg
            $error("compare_iter_nb: N must be a multiple of CHUNK, 1 <= CHUNK <= N");
        end
    endgenerate

    logic [1:0]       state;
    logic [N-1:0]     a_q, b_q;
    logic [2:0]       op_q;
    logic [IW-1:0]    idx;
    logic             decided, lt_q, r_q, err_q;
    logic [CHUNK-1:0] ca, cb;
    logic             c_lt, c_eq, sign_diff, diff, cur_lt, fin_eq, fin_lt, outcome, last;

    assign ca = a_q[idx*CHUNK +: CHUNK];
    assign cb = b_q[idx*CHUNK +: CHUNK];

    cmp_chunk_nb #(.CHUNK(CHUNK)) u_chunk (.a(ca), .b(cb), .lt(c_lt), .eq(c_eq));

    // Signed ops with differing sign bits are decided on the MSB chunk alone.
    always_comb begin
        sign_diff = (idx == LAST) && (op_q == CMP_LT || op_q == CMP_GE) && (a_q[N-1] ^ b_q[N-1]);
        diff      = sign_diff || !c_eq;
        cur_lt    = sign_diff ? a_q[N-1] : c_lt;
        fin_eq    = !(decided || diff);
        fin_lt    = decided ? lt_q : cur_lt;
        outcome   = (op_q == CMP_EQ) ? fin_eq :
                    (op_q == CMP_NE) ? !fin_eq :
                    (op_q == CMP_LT || op_q == CMP_LTU) ? fin_lt :
                    (op_q == CMP_GE || op_q == CMP_GEU) ? !fin_lt : 1'b0;
`ifdef CMP_EARLY_EXIT_EN
        last      = (idx == '0) || (diff && op_legal(op_q));
`else
        last      = (idx == '0);
`endif
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state   <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            idx     <= '0;
            decided <= 1'b0;
            lt_q    <= 1'b0;
            r_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (in_valid_i) begin
                    a_q     <= a_i;
                    b_q     <= b_i;
                    op_q    <= op_i;
                    idx     <= LAST;
                    decided <= 1'b0;
                    lt_q    <= 1'b0;
                    state   <= S_RUN;
                end
                S_RUN: begin
                    if (!decided && diff) begin
                        decided <= 1'b1;
                        lt_q    <= cur_lt;
                    end
                    if (last) begin
                        r_q   <= outcome;
                        err_q <= !op_legal(op_q);
                        state <= S_DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                S_DONE: if (out_ready_i) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready_o  = state == S_IDLE;
    assign out_valid_o = state == S_DONE;
    assign r_o         = {{(N-1){1'b0}}, r_q};
    assign err_o       = err_q;
endmodule

// File: tb/tb_compare_iter_nb.sv
// tb_compare_iter_nb: directed plus randomized checks of compare_iter_nb against a behavioural model
module tb_compare_iter_nb;
    logic        clk = 0, rstn = 0, in_valid = 0, out_ready = 0;
    logic [31:0] a = 0, b = 0;
    logic [2:0]  op = 0;
    logic        in_ready, out_valid, err;
    logic [31:0] r;
    int          checks = 0, failures = 0;

    compare_iter_nb #(.N(32), .CHUNK(8)) dut (
        .clk_i(clk), .rstn_i(rstn), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .a_i(a), .b_i(b), .op_i(op), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .r_o(r), .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [31:0] x, input logic [31:0] y, input logic [2:0] o,
                                  output logic res, output logic e, output int lat);
        logic legal, lt;
        legal = o inside {3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
        lt    = o[1] ? (x < y) : ($signed(x) < $signed(y));
        e     = !legal;
        res   = !legal ? 1'b0 : o[2] ? (lt ^ o[0]) : ((x == y) ^ o[0]);
        lat   = 4;
`ifdef CMP_EARLY_EXIT_EN
        if (legal && x != y) begin
            lat = 1;
            for (int c = 3; c > 0; c--) begin
                if (x[c*8 +: 8] != y[c*8 +: 8]) break;
                lat++;
            end
        end
`endif
    endfunction

    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [2:0] o, input int hold);
        logic er, ee;
        int   el, cyc;
        model(x, y, o, er, ee, el);
        @(negedge clk);
        check("ready_idle", in_ready, 1);
        a = x; b = y; op = o; in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0; a = $urandom; b = $urandom; op = 3'($urandom);
        cyc = 0;
        while (1) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (out_valid || cyc >= 20) break;
        end
        check("out_valid", out_valid, 1);
        check("latency", cyc, el);
        check("result", r, {31'b0, er});
        check("err", err, ee);
        check("ready_busy", in_ready, 0);
        repeat (hold) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_result", r, {31'b0, er});
            check("hold_err", err, ee);
            check("hold_ready", in_ready, 0);
        end
        out_ready = 1;
        @(posedge clk);
        #1 out_ready = 0;
        check("drained_valid", out_valid, 0);
        check("drained_ready", in_ready, 1);
    endtask

    initial begin
        logic [31:0] x, y;
        int sel;
        repeat (3) @(negedge clk);
        check("rst_ready", in_ready, 1);
        check("rst_valid", out_valid, 0);
        check("rst_result", r, 0);
        check("rst_err", err, 0);
        rstn = 1;
        run_op(32'hFFFFFFFF, 32'h00000001, 3'b100, 0);
        run_op(32'hFFFFFFFF, 32'h00000001, 3'b110, 1);
        run_op(32'h12345678, 32'h12345678, 3'b000, 0);
        run_op(32'h12345678, 32'h12345678, 3'b001, 0);
        run_op(32'h00000100, 32'h000000FF, 3'b101, 0);
        run_op(32'h80000000, 32'h7FFFFFFF, 3'b101, 0);
        run_op(32'h00000001, 32'h00000002, 3'b111, 2);
        run_op(32'hDEADBEEF, 32'h00000000, 3'b010, 5);
        run_op(32'h00000000, 32'h00000000, 3'b011, 0);
        // Asynchronous reset while an op is mid-RUN.
        @(negedge clk);
        a = 32'h1; b = 32'h1; op = 3'b000; in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
        @(posedge clk);
        #2 rstn = 0;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_ready", in_ready, 1);
        check("midrst_result", r, 0);
        @(negedge clk) rstn = 1;
        run_op(32'h00000005, 32'hFFFFFFF0, 3'b100, 0);
        for (int i = 0; i < 60; i++) begin
            x = $urandom;
            y = x;
            sel = $urandom_range(0, 5);
            if (sel < 4) begin
                y[sel*8 +: 8] = y[sel*8 +: 8] ^ 8'($urandom_range(1, 255));
                for (int c = 0; c < sel; c++) y[c*8 +: 8] = 8'($urandom);
            end else if (sel == 5) y = $urandom;
            run_op(x, y, 3'($urandom_range(0, 7)), $urandom_range(0, 2));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
